// File: rtl/console_text_writer.sv
// rtl/console_text_writer.sv - ASCII stream to linear character RAM writer with cursor, CR/LF/BS and row clearing.
// Optional CONSOLE_TAB_EN adds 8'h09 handling (advance to next multiple of 8, clearing skipped cells).
module console_text_writer #(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 48,
  parameter int         ADDR_W     = 13,
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic              vgaClock,
  input  logic              resetN,
  input  logic [7:0]        charIn,
  input  logic              charValid,
  output logic              charReady,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [7:0]        wrData,
  output logic              wrEn,
  output logic [6:0]        cursorCol,
  output logic [5:0]        cursorRow,
  output logic              busy
);

`ifdef CONSOLE_TAB_EN
  typedef enum logic [1:0] {S_CLEAR_ALL, S_IDLE, S_CLEAR_LINE, S_TAB} state_t;
`else
  typedef enum logic [1:0] {S_CLEAR_ALL, S_IDLE, S_CLEAR_LINE} state_t;
`endif

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(COLS * ROWS);
  localparam logic [6:0]      LAST_COL = 7'(COLS - 1);
  localparam logic [5:0]      LAST_ROW = 6'(ROWS - 1);

  function automatic logic [ADDR_W-1:0] base_of(input logic [5:0] r);
    return ADDR_W'(r) * ADDR_W'(COLS);
  endfunction

  state_t              state_q;
  logic [ADDR_W:0]     idx_q;
  logic [6:0]          clr_q;
  logic [ADDR_W-1:0]   line_base_q;
  logic [6:0]          col_q;
  logic [5:0]          row_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [7:0]          wr_data_q;
  logic [5:0]          next_row;
  logic [ADDR_W-1:0]   cur_addr;

  assign next_row = (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;
  assign cur_addr = base_of(row_q) + ADDR_W'(col_q);

  assign charReady = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign wrEn      = wr_en_q;
  assign wrAddr    = wr_addr_q;
  assign wrData    = wr_data_q;
  assign cursorCol = col_q;
  assign cursorRow = row_q;

  always_ff @(posedge vgaClock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_CLEAR_ALL;
      idx_q       <= '0;
      clr_q       <= '0;
      line_base_q <= '0;
      col_q       <= '0;
      row_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        S_CLEAR_ALL: begin
          // One idle cycle after the last write before charReady rises.
          if (idx_q == LAST_IDX) begin
            state_q <= S_IDLE;
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= idx_q[ADDR_W-1:0];
            wr_data_q <= CLEAR_CHAR;
            idx_q     <= idx_q + 1'b1;
          end
        end

        S_IDLE: begin
          if (charValid) begin
            if ((charIn >= 8'h20) && (charIn <= 8'h7E)) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= cur_addr;
              wr_data_q <= charIn;
              if (col_q == LAST_COL) begin
                col_q       <= '0;
                row_q       <= next_row;
                line_base_q <= base_of(next_row);
                clr_q       <= '0;
                state_q     <= S_CLEAR_LINE;
              end else begin
                col_q <= col_q + 7'd1;
              end
            end else if (charIn == 8'h0D) begin
              col_q <= '0;
            end else if (charIn == 8'h0A) begin
              col_q       <= '0;
              row_q       <= next_row;
              line_base_q <= base_of(next_row);
              clr_q       <= '0;
              state_q     <= S_CLEAR_LINE;
            end else if (charIn == 8'h08) begin
              if (col_q != 7'd0) begin
                col_q     <= col_q - 7'd1;
                wr_en_q   <= 1'b1;
                wr_addr_q <= cur_addr - ADDR_W'(1);
                wr_data_q <= CLEAR_CHAR;
              end
`ifdef CONSOLE_TAB_EN
            end else if (charIn == 8'h09) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= cur_addr;
              wr_data_q <= CLEAR_CHAR;
              if (col_q == LAST_COL) begin
                col_q       <= '0;
                row_q       <= next_row;
                line_base_q <= base_of(next_row);
                clr_q       <= '0;
                state_q     <= S_CLEAR_LINE;
              end else begin
                col_q <= col_q + 7'd1;
                if (col_q[2:0] != 3'd7) state_q <= S_TAB;
              end
`endif
            end
          end
        end

        S_CLEAR_LINE: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= line_base_q + ADDR_W'(clr_q);
          wr_data_q <= CLEAR_CHAR;
          if (clr_q == LAST_COL) begin
            state_q <= S_IDLE;
          end else begin
            clr_q <= clr_q + 7'd1;
          end
        end

`ifdef CONSOLE_TAB_EN
        S_TAB: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= cur_addr;
          wr_data_q <= CLEAR_CHAR;
          if (col_q == LAST_COL) begin
            col_q       <= '0;
            row_q       <= next_row;
            line_base_q <= base_of(next_row);
            clr_q       <= '0;
            state_q     <= S_CLEAR_LINE;
          end else begin
            col_q <= col_q + 7'd1;
            if (col_q[2:0] == 3'd7) state_q <= S_IDLE;
          end
        end
`endif

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
